// File: rtl/apb_pkg.sv
// Shared encodings for the APB master bridge: FSM states, target selects and
// the bit layout of a queued command word {wr, sel, addr, wdata}.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] PSEL_NONE = 2'b00;
    localparam logic [SEL_W-1:0] PSEL_GPIO = 2'b01;
    localparam logic [SEL_W-1:0] PSEL_UART = 2'b10;

    // Command word packs wdata at bit 0, then addr, then sel, then wr on top.
    function automatic int cmd_addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int cmd_sel_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int cmd_wr_bit(input int addr_w, input int data_w);
        return addr_w + data_w + SEL_W;
    endfunction

    function automatic logic sel_valid(input logic [SEL_W-1:0] s);
        return (s == PSEL_GPIO) || (s == PSEL_UART);
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from a registered occupancy count,
// so a pop in the same cycle never lets a full FIFO accept.
module apb_cmd_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: queues processor commands and runs each as a SETUP/ACCESS
// transfer, returning a one-cycle response with read data and error status.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] pAdd,
    output logic [DATA_W-1:0] pwData,
    output logic [1:0]        psel,
    output logic              pen,
    output logic              pwr,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              perr
);
    localparam int CMD_W  = 1 + SEL_W + ADDR_W + DATA_W;
    localparam int A_LSB  = cmd_addr_lsb(DATA_W);
    localparam int S_LSB  = cmd_sel_lsb(ADDR_W, DATA_W);
    localparam int WR_BIT = cmd_wr_bit(ADDR_W, DATA_W);
    localparam int TW     = $clog2(TIMEOUT + 1);

    apb_state_e        state, state_nxt;
    logic [CMD_W-1:0]  head;
    logic              fifo_full, fifo_empty, pop;
    logic              load, bus_idle, finish, inv_rsp, fin_err;
    logic [DATA_W-1:0] fin_rdata;
    logic [TW-1:0]     tcnt;

    apb_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata ({cmd_wr, cmd_sel, cmd_addr, cmd_wdata}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        bus_idle  = 1'b0;
        finish    = 1'b0;
        inv_rsp   = 1'b0;
        fin_err   = 1'b0;
        fin_rdata = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (sel_valid(head[S_LSB +: SEL_W])) begin
                        load      = 1'b1;
                        state_nxt = ST_SETUP;
                    end else begin
                        inv_rsp = 1'b1;
                    end
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                // pready wins over the timeout on the last allowed cycle
                if (pready || tcnt == TW'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    fin_err   = pready ? perr : 1'b1;
                    fin_rdata = (pready && !perr && !pwr) ? prdata : '0;
                    // an invalid head is left for IDLE so its response gets its own cycle
                    if (!fifo_empty && sel_valid(head[S_LSB +: SEL_W])) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        state_nxt = ST_SETUP;
                    end else begin
                        bus_idle  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            pAdd      <= '0;
            pwData    <= '0;
            psel      <= PSEL_NONE;
            pen       <= 1'b0;
            pwr       <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= finish || inv_rsp;
            rsp_err   <= finish ? fin_err : inv_rsp;
            rsp_rdata <= fin_rdata;
            if (load) begin
                psel   <= head[S_LSB +: SEL_W];
                pAdd   <= head[A_LSB +: ADDR_W];
                pwr    <= head[WR_BIT];
                pwData <= head[WR_BIT] ? head[DATA_W-1:0] : '0;
                pen    <= 1'b0;
            end else if (bus_idle) begin
                psel <= PSEL_NONE;
                pen  <= 1'b0;
                pwr  <= 1'b0;
            end else if (state == ST_SETUP) begin
                pen <= 1'b1;
            end
            if (state == ST_SETUP) tcnt <= '0;
            else if (state == ST_ACCESS && tcnt != TW'(TIMEOUT)) tcnt <= tcnt + TW'(1);
        end
    end

endmodule
